// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: generates the mic bit clock, samples the 1-bit stream
// and decimates it into unsigned ones-count PCM words on a valid/ready port.
module pdm_mic_rx #(
    parameter  int CLK_HZ  = 100000000,
    parameter  int MCLK_HZ = 2500000,
    parameter  int DECIM   = 64,
    localparam int HALF    = CLK_HZ / (2 * MCLK_HZ),
    localparam int W       = $clog2(DECIM + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         mic_data,
    output logic         mic_clk,
    output logic         mic_lrsel,
    output logic [W-1:0] pcm_data,
    output logic         pcm_valid,
    input  logic         pcm_ready,
    output logic         overrun
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HALF - 1);
    localparam logic [W-1:0]  BIT_LAST = W'(DECIM - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mclk_q, mclk_d;
    logic [W-1:0]  bitcnt_q, bitcnt_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  pcm_data_q, pcm_data_d;
    logic          pcm_valid_q, pcm_valid_d;
    logic          overrun_q, overrun_d;

    logic          mic_s;
    logic [W-1:0]  word;
    logic          word_done;
    logic          transfer;

    always_comb begin
        sync_d      = {sync_q[0], mic_data};
        mic_s       = sync_q[1];
        cnt_d       = cnt_q;
        mclk_d      = mclk_q;
        bitcnt_d    = bitcnt_q;
        acc_d       = acc_q;
        pcm_data_d  = pcm_data_q;
        pcm_valid_d = pcm_valid_q;
        overrun_d   = overrun_q;
        word_done   = 1'b0;
        // acc never exceeds DECIM-1 here, so adding the last bit cannot wrap.
        word        = acc_q + W'(mic_s);
        transfer    = pcm_valid_q && pcm_ready;

        if (!en) begin
            cnt_d    = CNT_LOAD;
            mclk_d   = 1'b0;
            bitcnt_d = '0;
            acc_d    = '0;
        end else if (cnt_q == '0) begin
            cnt_d  = CNT_LOAD;
            mclk_d = ~mclk_q;
            // End of the high phase: the mic output is settled, take the bit.
            if (mclk_q) begin
                if (bitcnt_q == BIT_LAST) begin
                    word_done = 1'b1;
                    bitcnt_d  = '0;
                    acc_d     = '0;
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                    acc_d    = word;
                end
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
        end

        if (transfer) begin
            pcm_valid_d = 1'b0;
        end
        if (word_done) begin
            pcm_valid_d = 1'b1;
            pcm_data_d  = word;
            if (pcm_valid_q && !pcm_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            cnt_q       <= CNT_LOAD;
            mclk_q      <= 1'b0;
            bitcnt_q    <= '0;
            acc_q       <= '0;
            pcm_data_q  <= '0;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            mclk_q      <= mclk_d;
            bitcnt_q    <= bitcnt_d;
            acc_q       <= acc_d;
            pcm_data_q  <= pcm_data_d;
            pcm_valid_q <= pcm_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mic_clk   = mclk_q;
    assign mic_lrsel = 1'b0;
    assign pcm_data  = pcm_data_q;
    assign pcm_valid = pcm_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdm_mic_rx.sv
// Directed bench for pdm_mic_rx: expected PCM words are queued when the input
// pattern is chosen and compared as each word appears on the output port.
module tb_pdm_mic_rx;

    localparam int DECIM = 64;
    localparam int HALF  = 20;
    localparam int W     = 7;
    localparam int WIN   = 2 * HALF * DECIM;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         mic_data;
    logic         mic_clk;
    logic         mic_lrsel;
    logic [W-1:0] pcm_data;
    logic         pcm_valid;
    logic         pcm_ready;
    logic         overrun;

    int checks = 0;
    int errors = 0;
    int sb[$];
    bit alt_mode = 1'b0;

    pdm_mic_rx #(
        .CLK_HZ (100000000),
        .MCLK_HZ(2500000),
        .DECIM  (DECIM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mic_data (mic_data),
        .mic_clk  (mic_clk),
        .mic_lrsel(mic_lrsel),
        .pcm_data (pcm_data),
        .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; in alternating mode mic_data flips right after each mic_clk rise.
    task automatic tick();
        logic prev;
        prev = mic_clk;
        @(posedge clk);
        #1;
        if (alt_mode && mic_clk === 1'b1 && prev === 1'b0) mic_data = ~mic_data;
    endtask

    task automatic wait_valid(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (pcm_valid !== 1'b1 && n < 3 * WIN) begin
            tick();
            n++;
        end
        check(tag, n, exp_cycles);
    endtask

    task automatic pop_check(input string tag);
        int exp;
        exp = (sb.size() > 0) ? sb.pop_front() : -1;
        $display("word %s data=%0d expected=%0d overrun=%0b", tag, pcm_data, exp, overrun);
        check(tag, pcm_data, exp);
    endtask

    task automatic start(input logic d);
        reset     = 1'b1;
        en        = 1'b0;
        pcm_ready = 1'b1;
        alt_mode  = 1'b0;
        mic_data  = d;
        repeat (3) tick();
        reset = 1'b0;
        en    = 1'b1;
    endtask

    initial begin
        int n, rise1, fall1, rise2;
        bit seen_high, seen_lr, moved;

        // Constant ones, also covers the reset state.
        start(1'b1);
        check("rst_mic_clk", mic_clk, 0);
        check("rst_lrsel", mic_lrsel, 0);
        check("rst_pcm_data", pcm_data, 0);
        check("rst_pcm_valid", pcm_valid, 0);
        check("rst_overrun", overrun, 0);
        sb.push_back(DECIM);
        sb.push_back(DECIM);
        wait_valid("ones_latency", WIN);
        pop_check("ones_w0");
        tick();
        check("ones_pulse_len", pcm_valid, 0);
        wait_valid("ones_period", WIN - 1);
        pop_check("ones_w1");
        check("ones_overrun", overrun, 0);

        // Constant zeros.
        start(1'b0);
        sb.push_back(0);
        sb.push_back(0);
        wait_valid("zeros_latency", WIN);
        pop_check("zeros_w0");
        tick();
        wait_valid("zeros_period", WIN - 1);
        pop_check("zeros_w1");

        // Alternating bits: half the window is ones.
        start(1'b0);
        alt_mode = 1'b1;
        sb.push_back(DECIM / 2);
        sb.push_back(DECIM / 2);
        wait_valid("alt_latency", WIN);
        pop_check("alt_w0");
        tick();
        wait_valid("alt_period", WIN - 1);
        pop_check("alt_w1");
        alt_mode = 1'b0;

        // mic_clk waveform, then drop en after 10 strobes.
        start(1'b1);
        rise1 = -1; fall1 = -1; rise2 = -1; seen_lr = 1'b0;
        for (int i = 1; i <= 10 * 2 * HALF; i++) begin
            logic prev;
            prev = mic_clk;
            tick();
            if (mic_lrsel !== 1'b0) seen_lr = 1'b1;
            if (mic_clk === 1'b1 && prev === 1'b0) begin
                if (rise1 < 0) rise1 = i;
                else if (rise2 < 0) rise2 = i;
            end
            if (mic_clk === 1'b0 && prev === 1'b1 && fall1 < 0) fall1 = i;
        end
        check("mclk_first_rise", rise1, HALF);
        check("mclk_high_time", fall1 - rise1, HALF);
        check("mclk_period", rise2 - rise1, 2 * HALF);
        check("lrsel_low", seen_lr, 0);
        en = 1'b0;
        seen_high = 1'b0;
        repeat (100) begin
            tick();
            if (mic_clk !== 1'b0) seen_high = 1'b1;
        end
        check("mclk_idle_low", seen_high, 0);
        check("partial_discarded", pcm_valid, 0);
        en = 1'b1;
        sb.push_back(DECIM);
        wait_valid("restart_latency", WIN);
        pop_check("restart_w0");

        // Reset in the middle of a window while mic_clk is high.
        repeat (300) tick();
        n = 0;
        while (mic_clk !== 1'b1 && n < 4 * HALF) begin
            tick();
            n++;
        end
        reset = 1'b1;
        tick();
        check("midrst_mic_clk", mic_clk, 0);
        check("midrst_pcm_data", pcm_data, 0);
        check("midrst_pcm_valid", pcm_valid, 0);
        reset = 1'b0;

        // Backpressure: two windows unconsumed, ones then zeros.
        start(1'b1);
        pcm_ready = 1'b0;
        sb.push_back(DECIM);
        sb.push_back(0);
        wait_valid("bp_latency", WIN);
        pop_check("bp_w0");
        mic_data = 1'b0;
        n = 0;
        moved = 1'b0;
        while (overrun !== 1'b1 && n < 3 * WIN) begin
            tick();
            n++;
            if (overrun !== 1'b1 && (pcm_valid !== 1'b1 || pcm_data !== W'(DECIM))) moved = 1'b1;
        end
        check("bp_overrun_cycle", n, WIN);
        check("bp_held_stable", moved, 0);
        check("bp_valid_held", pcm_valid, 1);
        pop_check("bp_w1");
        pcm_ready = 1'b1;
        tick();
        pcm_ready = 1'b0;
        check("bp_consume_valid", pcm_valid, 0);
        check("bp_overrun_sticky", overrun, 1);
        repeat (50) tick();
        check("bp_overrun_still", overrun, 1);
        reset = 1'b1;
        tick();
        check("bp_rst_overrun", overrun, 0);
        check("bp_rst_valid", pcm_valid, 0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pdm_mic_rx.md
# pdm_mic_rx

Receive side of the on-board PDM microphone interface in the PCM audio path. The block generates the microphone bit clock and samples the 1-bit PDM stream. It decimates the stream by counting ones over a fixed window and presents each unsigned PCM word on a valid/ready output port. It sits between the Nexys4 MEMS microphone pins and the PCM buffer/playback logic.

## Interface
Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- MCLK_HZ, 2500000, microphone clock frequency in Hz. CLK_HZ must equal an integer multiple of 2*MCLK_HZ.
- DECIM, 64, PDM bits per PCM word. Must be at least 2.
- Derived, not overridable:
  - HALF = CLK_HZ/(2*MCLK_HZ), 20 by default.
  - W = clog2(DECIM+1), 7 by default.

Ports:
- clk, input, 1, system clock; all logic is on its rising edge.
- reset, input, 1, synchronous, active-high.
- en, input, 1, run enable.
- mic_data, input, 1, asynchronous PDM data from the microphone.
- mic_clk, output, 1, microphone bit clock, 50 % duty cycle.
- mic_lrsel, output, 1, channel select; constant 0.
- pcm_data, output, W, unsigned ones-count of the last completed window, range 0..DECIM.
- pcm_valid, output, 1, pcm_data holds an unconsumed word.
- pcm_ready, input, 1, consumer accepts the word this cycle.
- overrun, output, 1, sticky flag: an unconsumed word was overwritten.

## Operation
- Input sync: mic_data passes through a 2-flop synchronizer giving mic_s. Both flops reset to 0.
- Idle (reset=1 or en=0):
  - Half-period counter loads HALF-1.
  - mic_clk=0.
  - Bit counter and accumulator clear to 0.
- Run (en=1): the half-period counter decrements each cycle.
  - When it reaches 0: toggle mic_clk and reload HALF-1.
- Sample strobe: the cycle where counter==0, mic_clk==1 and en==1, i.e. the end of the high phase.
  - On each strobe, acc <= acc + mic_s and bitcnt <= bitcnt + 1.
- Window end: the strobe where bitcnt==DECIM-1.
  - The word is acc + mic_s, which is never truncated because W covers 0..DECIM.
  - It is loaded into the pcm_data register.
  - acc and bitcnt clear to 0 in the same cycle, so there are no lost bits between windows.
- Output handshake:
  - A transfer occurs on any cycle with pcm_valid=1 and pcm_ready=1.
  - On a transfer with no new word, pcm_valid <= 0.
  - On a new word, pcm_valid <= 1 and pcm_data <= word, regardless of pcm_ready.
  - If a new word loads while pcm_valid=1 and pcm_ready=0, the old word is lost and overrun <= 1.
  - If a new word loads while pcm_valid=1 and pcm_ready=1, the old word transfers, the new word loads, pcm_valid stays 1, and there is no overrun.
  - pcm_data is stable while pcm_valid=1 and not consumed.
- en deassert mid-window: the partial window is discarded. pcm_data, pcm_valid and overrun are unchanged, and the handshake still operates. The next run starts a fresh window.
- overrun clears only on reset.
- Output format: silence is approximately DECIM/2. Downstream logic applies the offset.

## Timing
- Reset values:
  - mic_clk=0, mic_lrsel=0.
  - pcm_data=0, pcm_valid=0, overrun=0.
  - Counter=HALF-1, bitcnt=0, acc=0, sync flops=0.
- Reset overrides en and pcm_ready in the same cycle.
- Cycle numbering: cycle 1 is the first rising edge with en=1 (and reset=0).
  - mic_clk rises at the end of cycle HALF and falls at the end of cycle 2*HALF.
  - Period is 2*HALF cycles (40 by default).
- Strobes fall on cycles k*2*HALF.
  - The first pcm_valid rises after cycle 2*HALF*DECIM, seen at cycle 2*HALF*DECIM+1 (2561 by default).
  - Subsequent words follow every 2*HALF*DECIM cycles (2560).
- Sampling latency: a strobe captures mic_data as it was 2 clk edges earlier.
- pcm_valid falls the cycle after the consuming edge. There is no combinational path from pcm_ready to any output.

## Test plan
- Constant ones: reset, en=1, mic_data=1, pcm_ready=1. Required:
  - pcm_valid pulses 1 cycle at cycle 2561 with pcm_data=64, then every 2560 cycles.
  - overrun=0.
- Constant zeros: same setup with mic_data=0. Required: pcm_data=0 on every word.
- Alternating data: mic_data toggles on each mic_clk rising edge. Required: pcm_data=32 on every word.
- mic_clk timing: mic_clk period is 40 cycles with a high time of 20. mic_lrsel=0 throughout. mic_clk stays 0 while en=0.
- Backpressure: pcm_ready=0 for two windows with constant ones, then zeros. Required:
  - pcm_valid=1 from cycle 2561.
  - overrun=1 at cycle 5121, with pcm_data=0 (second window).
  - pcm_ready=1 for one cycle clears pcm_valid; overrun stays 1 until reset.
- en drop and reset mid-window: mic_data=1; drop en after 10 strobes, wait 100 cycles, re-assert. Required:
  - The first word arrives 2560 cycles after re-assert, with pcm_data=64.
  - Asserting reset mid-window returns all outputs to their reset values the following cycle.
